// File: rtl/e_mdu_ctrl.sv
// E-stage multiply/divide sequencer: holds architectural HI/LO, counts out the
// fixed mult/div latency and raises the stall that protects HI/LO readers in D.
module e_mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  MDop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_IsMd,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} stateT;

  stateT       state;
  logic [3:0]  count;
  logic [31:0] pendHi, pendLo;
  logic        pendWrite;

  logic [63:0] sProd, uProd;
  logic [31:0] magA, magB, safeMagB, safeB;
  logic [31:0] magQ, magR, uQ, uR;
  logic [31:0] resHi, resLo;
  logic        resWrite;

  assign sProd = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign uProd = {32'd0, A} * {32'd0, B};

  // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000; a zero divisor is replaced by 1 only to keep the divider X-free.
  always_comb begin
    magA     = A[31] ? (~A + 32'd1) : A;
    magB     = B[31] ? (~B + 32'd1) : B;
    safeMagB = (magB == 32'd0) ? 32'd1 : magB;
    safeB    = (B == 32'd0) ? 32'd1 : B;
    magQ     = magA / safeMagB;
    magR     = magA % safeMagB;
    uQ       = A / safeB;
    uR       = A % safeB;
    resHi    = 32'd0;
    resLo    = 32'd0;
    resWrite = 1'b0;
    case (MDop)
      3'd0: begin
        {resHi, resLo} = sProd;
        resWrite       = 1'b1;
      end
      3'd1: begin
        {resHi, resLo} = uProd;
        resWrite       = 1'b1;
      end
      3'd2: begin
        resLo    = (A[31] ^ B[31]) ? (~magQ + 32'd1) : magQ;
        resHi    = A[31] ? (~magR + 32'd1) : magR;
        resWrite = (B != 32'd0);
      end
      3'd3: begin
        resLo    = uQ;
        resHi    = uR;
        resWrite = (B != 32'd0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      Busy      <= 1'b0;
      count     <= 4'd0;
      pendHi    <= 32'd0;
      pendLo    <= 32'd0;
      pendWrite <= 1'b0;
      HI        <= 32'd0;
      LO        <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            case (MDop)
              3'd0, 3'd1, 3'd2, 3'd3: begin
                pendHi    <= resHi;
                pendLo    <= resLo;
                pendWrite <= resWrite;
                count     <= MDop[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                state     <= RUN;
                Busy      <= 1'b1;
              end
              3'd4:    HI <= A;
              3'd5:    LO <= A;
              default: ;
            endcase
          end
        end
        RUN: begin
          count <= count - 4'd1;
          if (count == 4'd1) begin
            state <= IDLE;
            Busy  <= 1'b0;
            if (pendWrite) begin
              HI <= pendHi;
              LO <= pendLo;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Start is included because Busy only rises on the edge after it.
  assign Stall = D_IsMd & (Start | Busy);

endmodule
